// File: rtl/fetch_packet_compactor_pkg.sv
// Shared fetch-side constants and types for the fetch packet compactor.
package fetch_packet_compactor_pkg;

  localparam int FETCH_WIDTH = 4;
  localparam int LANE_CNT_W  = $clog2(FETCH_WIDTH + 1);

  typedef logic [FETCH_WIDTH-1:0] fetch_mask_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_FULL
  } occ_state_t;

endpackage

// File: rtl/fetch_packet_compactor_mask_compactor.sv
// Combinational slot packer: moves valid slots to contiguous low lanes, order kept.
module mask_compactor
  import fetch_packet_compactor_pkg::*;
#(
  parameter int IN_WIDTH   = FETCH_WIDTH,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = $clog2(IN_WIDTH + 1)
) (
  input  logic [IN_WIDTH-1:0]            mask_i,
  input  logic [IN_WIDTH*DATA_WIDTH-1:0] data_i,
  output logic [IN_WIDTH*DATA_WIDTH-1:0] data_o,
  output logic [IN_WIDTH-1:0]            mask_o,
  output logic [CNT_W-1:0]               cnt_o
);

  logic [CNT_W-1:0] prefix [IN_WIDTH];
  logic [CNT_W-1:0] run_cnt;

  // prefix[i] is the destination lane of slot i when that slot is valid
  always_comb begin
    run_cnt = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      prefix[i] = run_cnt;
      run_cnt   = run_cnt + CNT_W'(mask_i[i]);
    end
    cnt_o = run_cnt;
  end

  always_comb begin
    data_o = '0;
    mask_o = '0;
    for (int k = 0; k < IN_WIDTH; k++) begin
      mask_o[k] = (CNT_W'(k) < cnt_o);
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (mask_i[i] && (prefix[i] == CNT_W'(k))) begin
          data_o[k*DATA_WIDTH +: DATA_WIDTH] = data_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/fetch_packet_compactor.sv
// Packs sparse fetch packets and registers them behind a main + skid pair.
// Optional perf counters are built when FETCH_COMPACT_PERF_EN is defined.
//
//   state     | meaning
//   OCC_EMPTY | main and skid both invalid
//   OCC_ONE   | main valid, skid invalid
//   OCC_FULL  | main and skid both valid, upstream stalled
module fetch_packet_compactor
  import fetch_packet_compactor_pkg::*;
#(
  parameter int IN_WIDTH   = FETCH_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush_i,
  input  logic                           in_valid_i,
  input  logic [IN_WIDTH-1:0]            in_mask_i,
  input  logic [IN_WIDTH*DATA_WIDTH-1:0] in_data_i,
  output logic                           in_ready_o,
  output logic [IN_WIDTH-1:0]            out_valid_o,
  input  logic                           out_ready_i,
  output logic [IN_WIDTH*DATA_WIDTH-1:0] out_data_o
`ifdef FETCH_COMPACT_PERF_EN
  ,
  output logic [31:0]                    perf_push_cnt_o,
  output logic [31:0]                    perf_stall_cnt_o
`endif
);

  localparam int CNT_W = $clog2(IN_WIDTH + 1);

  occ_state_t                    state_q, state_d;
  logic                          in_ready_q, in_ready_d;
  logic [IN_WIDTH-1:0]           m_mask_q, m_mask_d, s_mask_q, s_mask_d;
  logic [IN_WIDTH*DATA_WIDTH-1:0] m_data_q, m_data_d, s_data_q, s_data_d;

  logic [IN_WIDTH-1:0]            pk_mask;
  logic [IN_WIDTH*DATA_WIDTH-1:0] pk_data;
  logic [CNT_W-1:0]               pk_cnt;
  logic                           acc, pk_load, push;

  mask_compactor #(
    .IN_WIDTH   (IN_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_compact (
    .mask_i (in_mask_i),
    .data_i (in_data_i),
    .data_o (pk_data),
    .mask_o (pk_mask),
    .cnt_o  (pk_cnt)
  );

  // Empty packets are consumed by acc but never load a register.
  assign acc     = in_valid_i & in_ready_q & ~flush_i;
  assign pk_load = acc & (pk_cnt != '0);
  assign push    = (|m_mask_q) & out_ready_i;

  always_comb begin
    state_d  = state_q;
    m_mask_d = m_mask_q;
    m_data_d = m_data_q;
    s_mask_d = s_mask_q;
    s_data_d = s_data_q;
    if (flush_i) begin
      state_d  = OCC_EMPTY;
      m_mask_d = '0;
      m_data_d = '0;
      s_mask_d = '0;
      s_data_d = '0;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (pk_load) begin
            m_mask_d = pk_mask;
            m_data_d = pk_data;
            state_d  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push) begin
            m_mask_d = pk_load ? pk_mask : '0;
            m_data_d = pk_load ? pk_data : '0;
            state_d  = pk_load ? OCC_ONE : OCC_EMPTY;
          end else if (pk_load) begin
            s_mask_d = pk_mask;
            s_data_d = pk_data;
            state_d  = OCC_FULL;
          end
        end
        OCC_FULL: begin
          if (push) begin
            m_mask_d = s_mask_q;
            m_data_d = s_data_q;
            s_mask_d = pk_load ? pk_mask : '0;
            s_data_d = pk_load ? pk_data : '0;
            state_d  = pk_load ? OCC_FULL : OCC_ONE;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
    in_ready_d = (state_d != OCC_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= OCC_EMPTY;
      in_ready_q <= 1'b1;
      m_mask_q   <= '0;
      m_data_q   <= '0;
      s_mask_q   <= '0;
      s_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      m_mask_q   <= m_mask_d;
      m_data_q   <= m_data_d;
      s_mask_q   <= s_mask_d;
      s_data_q   <= s_data_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = m_mask_q;
  assign out_data_o  = m_data_q;

`ifdef FETCH_COMPACT_PERF_EN
  logic [31:0] push_cnt_q, push_cnt_d, stall_cnt_q, stall_cnt_d;
  logic [31:0] push_lanes;

  // Counters ignore flush; only reset clears them.
  always_comb begin
    push_lanes = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      push_lanes = push_lanes + 32'(m_mask_q[i]);
    end
    push_cnt_d  = push ? (push_cnt_q + push_lanes) : push_cnt_q;
    stall_cnt_d = ((|m_mask_q) & ~out_ready_i) ? (stall_cnt_q + 32'd1) : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      push_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      push_cnt_q  <= push_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_push_cnt_o  = push_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_packet_compactor.sv
// Bench for fetch_packet_compactor: directed scenarios plus random traffic
// against a queue-based packet model. Perf checks when FETCH_COMPACT_PERF_EN is defined.
module tb_fetch_packet_compactor;
  import fetch_packet_compactor_pkg::*;

  localparam int W  = FETCH_WIDTH;
  localparam int DW = 32;
  localparam int BW = W * DW;

  logic          clk = 1'b0;
  logic          rst_n, flush_i, in_valid_i, out_ready_i, in_ready_o;
  fetch_mask_t   in_mask_i, out_valid_o;
  logic [BW-1:0] in_data_i, out_data_o;
`ifdef FETCH_COMPACT_PERF_EN
  logic [31:0]   perf_push_cnt_o, perf_stall_cnt_o;
`endif

  always #5 clk = ~clk;

  fetch_packet_compactor #(.IN_WIDTH(W), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_mask_i   (in_mask_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o)
`ifdef FETCH_COMPACT_PERF_EN
    ,
    .perf_push_cnt_o  (perf_push_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
  );

  typedef struct {
    fetch_mask_t   mask;
    logic [BW-1:0] data;
  } pkt_t;

  pkt_t        pq[$];
  bit          exp_rdy;
  logic [31:0] exp_push, exp_stall;
  int          total, bad;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference packing: walk slots in order, append each valid one to the next lane.
  function automatic pkt_t pack(input fetch_mask_t m, input logic [BW-1:0] d);
    pkt_t r;
    int   n;
    r.mask = '0;
    r.data = '0;
    n = 0;
    for (int i = 0; i < W; i++) begin
      if (m[i]) begin
        r.data[n*DW +: DW] = d[i*DW +: DW];
        r.mask[n] = 1'b1;
        n++;
      end
    end
    return r;
  endfunction

  task automatic check_outputs();
    pkt_t f;
    f.mask = '0;
    f.data = '0;
    if (pq.size() > 0) f = pq[0];
    chk("out_valid", BW'(out_valid_o), BW'(f.mask));
    chk("out_data", out_data_o, f.data);
    chk("in_ready", BW'(in_ready_o), BW'(exp_rdy));
`ifdef FETCH_COMPACT_PERF_EN
    chk("perf_push", BW'(perf_push_cnt_o), BW'(exp_push));
    chk("perf_stall", BW'(perf_stall_cnt_o), BW'(exp_stall));
`endif
  endtask

  // Called at a negedge; returns at the next negedge with outputs checked.
  task automatic step(input logic v, input fetch_mask_t m, input logic [BW-1:0] d,
                      input logic ordy, input logic fl);
    bit acc;
    in_valid_i  = v;
    in_mask_i   = m;
    in_data_i   = d;
    out_ready_i = ordy;
    flush_i     = fl;
    @(posedge clk);
    acc = v && exp_rdy && !fl;
    if (pq.size() > 0) begin
      if (ordy) exp_push = exp_push + 32'($countones(pq[0].mask));
      else      exp_stall = exp_stall + 32'd1;
    end
    if (fl) begin
      pq.delete();
    end else begin
      if (pq.size() > 0 && ordy) void'(pq.pop_front());
      if (acc && m != '0) pq.push_back(pack(m, d));
    end
    exp_rdy = (pq.size() < 2);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    in_valid_i  = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
    @(posedge clk);
    pq.delete();
    exp_rdy   = 1'b1;
    exp_push  = '0;
    exp_stall = '0;
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
  endtask

  function automatic logic [BW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [BW-1:0] d_abcd, p1, p2, p3;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    in_mask_i = '0;
    in_data_i = '0;
    out_ready_i = 1'b0;
    exp_rdy = 1'b1;
    exp_push = '0;
    exp_stall = '0;
    @(negedge clk);
    do_reset();
    chk("reset_rdy", BW'(in_ready_o), BW'(1'b1));
    chk("reset_valid", BW'(out_valid_o), '0);

    // Sparse mask: slots A,B,C,D with 1010 -> lanes B,D
    d_abcd = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
    step(1'b1, 4'b1010, d_abcd, 1'b1, 1'b0);
    chk("sparse_mask", BW'(out_valid_o), BW'(4'b0011));
    chk("sparse_l0", BW'(out_data_o[31:0]), BW'(32'hBBBB_0002));
    chk("sparse_l1", BW'(out_data_o[63:32]), BW'(32'hDDDD_0004));
    chk("sparse_hi", BW'(out_data_o[127:64]), '0);

    // Empty mask consumed, then a full packet passes unchanged
    step(1'b1, 4'b0000, rnd_data(), 1'b1, 1'b0);
    chk("empty_valid", BW'(out_valid_o), '0);
    step(1'b1, 4'b1111, d_abcd, 1'b1, 1'b0);
    chk("full_mask", BW'(out_valid_o), BW'(4'b1111));
    chk("full_data", out_data_o, d_abcd);
    step(1'b0, 4'b0000, '0, 1'b1, 1'b0);

    // Backpressure: P1 in M, P2 in S, P3 held upstream
    p1 = rnd_data(); p2 = rnd_data(); p3 = rnd_data();
    step(1'b1, 4'b0011, p1, 1'b0, 1'b0);
    chk("bp_p1_mask", BW'(out_valid_o), BW'(4'b0011));
    step(1'b1, 4'b0101, p2, 1'b0, 1'b0);
    chk("bp_rdy_low", BW'(in_ready_o), '0);
    chk("bp_stable", out_data_o[63:0], p1[63:0]);
    step(1'b1, 4'b1110, p3, 1'b0, 1'b0);
    chk("bp_rdy_held", BW'(in_ready_o), '0);
    step(1'b1, 4'b1110, p3, 1'b1, 1'b0);
    chk("bp_p2_l0", BW'(out_data_o[31:0]), BW'(p2[31:0]));
    chk("bp_p2_l1", BW'(out_data_o[63:32]), BW'(p2[95:64]));
    step(1'b1, 4'b1110, p3, 1'b1, 1'b0);
    chk("bp_p3_mask", BW'(out_valid_o), BW'(4'b0111));
    chk("bp_p3_l0", BW'(out_data_o[31:0]), BW'(p3[63:32]));
    step(1'b0, 4'b0000, '0, 1'b1, 1'b0);
    chk("bp_drained", BW'(out_valid_o), '0);

    // Flush while FULL with P3 presented
    step(1'b1, 4'b0011, p1, 1'b0, 1'b0);
    step(1'b1, 4'b0101, p2, 1'b0, 1'b0);
    step(1'b1, 4'b1110, p3, 1'b0, 1'b1);
    chk("flush_valid", BW'(out_valid_o), '0);
    chk("flush_rdy", BW'(in_ready_o), BW'(1'b1));
    step(1'b0, 4'b0000, '0, 1'b1, 1'b0);
    chk("flush_after", BW'(out_valid_o), '0);

    // Reset mid-stall
    step(1'b1, 4'b1111, p1, 1'b0, 1'b0);
    step(1'b1, 4'b1001, p2, 1'b0, 1'b0);
    do_reset();
    chk("rst_valid", BW'(out_valid_o), '0);
    chk("rst_data", out_data_o, '0);
    chk("rst_rdy", BW'(in_ready_o), BW'(1'b1));
`ifdef FETCH_COMPACT_PERF_EN
    chk("rst_perf_push", BW'(perf_push_cnt_o), '0);
    chk("rst_perf_stall", BW'(perf_stall_cnt_o), '0);

    // Perf: push 0111 then 0001, stall 5 cycles
    step(1'b1, 4'b0111, rnd_data(), 1'b1, 1'b0);
    step(1'b1, 4'b0001, rnd_data(), 1'b1, 1'b0);
    repeat (5) step(1'b0, 4'b0000, '0, 1'b0, 1'b0);
    step(1'b0, 4'b0000, '0, 1'b1, 1'b0);
    chk("perf_push_4", BW'(perf_push_cnt_o), BW'(32'd4));
    chk("perf_stall_5", BW'(perf_stall_cnt_o), BW'(32'd5));
`endif

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 9) < 7), fetch_mask_t'($urandom_range(0, 15)), rnd_data(),
             ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_packet_compactor.md
# fetch_packet_compactor

Sits directly upstream of the multi-channel fetch buffer FIFO and converts each fetch packet into the form that buffer accepts. A packet arrives with an arbitrary, possibly sparse, slot-valid mask; this block packs the valid slots into contiguous lanes starting at lane 0, keeping their order. It registers the result behind a valid/ready handshake with a one-entry skid. The buffer's all-or-nothing `write_ready` drives the output side directly.

## Interface
- `IN_WIDTH`, 4: slots per fetch packet. Equals the FIFO's write port count.
- `DATA_WIDTH`, 32: bits per slot, e.g. instruction plus predecode.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `flush_i`  in  1  synchronous pipeline flush. Discards all held packets.
- `in_valid_i`  in  1  packet present this cycle.
- `in_mask_i`  in  IN_WIDTH  per-slot valid. Any bit pattern is legal.
- `in_data_i`  in  IN_WIDTH×DATA_WIDTH  slot payloads.
- `in_ready_o`  out  1  block can accept a packet this cycle. Registered.
- `out_valid_o`  out  IN_WIDTH  packed lane mask. Always of the form 0…01…1; zero means no packet.
- `out_ready_i`  in  1  downstream accepts the whole packet this cycle.
- `out_data_o`  out  IN_WIDTH×DATA_WIDTH  packed payloads.
- Under `FETCH_COMPACT_PERF_EN` only:
  - `perf_push_cnt_o`  out  32  count of slots delivered.
  - `perf_stall_cnt_o`  out  32  count of backpressure cycles.

## Operation
- **Accept:** `acc = in_valid_i & in_ready_o & ~flush_i`.
- **Packing rule:** output lane k carries the (k+1)-th set bit of `in_mask_i`, counting from bit 0. The output mask has popcount(`in_mask_i`) low bits set. Unused lanes have data forced to 0.
- **Empty packets:** an accepted packet with an all-zero mask is consumed and produces no output. It never occupies a register.
- **Push:** `push = |out_valid_o & out_ready_i`. The downstream takes the entire packet; partial consumption does not exist.
- **Storage:** a main register M, which drives the outputs, and a skid register S.
  - Packed packet accepted while M is empty or pushing this cycle → loads M.
  - Otherwise it loads S.
  - On push with S full, S moves to M.
  - If S moves to M and a new packet is accepted in the same cycle, the new packet loads S.
- **Occupancy states:**
  - EMPTY: M invalid, S invalid.
  - ONE: M valid, S invalid.
  - FULL: M valid, S valid.
  - `in_ready_o` is the registered value of "next state ≠ FULL".
- **Flush:** all state goes to EMPTY in the following cycle. A packet presented in the flush cycle is discarded. Flush takes priority over push and accept.
- **Reset:** same effect as flush, and additionally clears the perf counters.

## Timing
- Latency is 1 cycle: a packet accepted at edge N is on `out_*` after edge N, provided M is free.
- Throughput is 1 packet/cycle while `out_ready_i` stays high.
- No combinational path from `out_ready_i` to `in_ready_o`. No combinational path from `in_*` to `out_*`.
- Reset and flush output values:
  - `out_valid_o` = 0.
  - `out_data_o` = 0.
  - `in_ready_o` = 1 from the first cycle after reset is released.
- Backpressure: `out_ready_i` low with M valid → M and S hold. A second accepted packet fills S, and `in_ready_o` drops in the next cycle.
- `out_valid_o` and `out_data_o` are stable while stalled.

## Configuration
- Macro: `FETCH_COMPACT_PERF_EN`.
- When defined:
  - `perf_push_cnt_o` increases by popcount(`out_valid_o`) on every push.
  - `perf_stall_cnt_o` increments on each cycle with `|out_valid_o & ~out_ready_i`.
  - Both wrap modulo 2^32. Both are cleared by reset only, not by flush.
- When undefined: the perf ports and counters are absent. Functionality is otherwise identical.

## Structure
- Shared core package holds:
  - `FETCH_WIDTH` (drives `IN_WIDTH`).
  - `fetch_mask_t`, `logic [FETCH_WIDTH-1:0]`.
  - The lane-count width constant `$clog2(FETCH_WIDTH+1)`.
- Sub-module `mask_compactor` (purely combinational):
  - Computes a prefix popcount per slot and selects each output lane by one-hot match.
  - Outputs the packed data, the packed mask and the count.
  - It is instantiated once, on the input side before the registers.

## Test plan
- **Sparse mask:** mask 4'b1010 with slots A,B,C,D, `out_ready_i`=1 → next cycle `out_valid_o`=4'b0011, lane0=B, lane1=D, lanes 2–3 = 0.
- **Empty mask:** mask 4'b0000 accepted → `out_valid_o` stays 0. A following packet with mask 4'b1111 appears next cycle unchanged.
- **Backpressure:**
  - Setup: `out_ready_i`=0, three back-to-back packets P1,P2,P3.
  - P1 sits in M and P2 in S. `in_ready_o` goes low one cycle after P2 is accepted, and P3 is held upstream.
  - Release `out_ready_i` → P1, P2, P3 emerge in order on consecutive cycles.
- **Flush while FULL:** flush with P3 presented in the same cycle → next cycle `out_valid_o`=0 and `in_ready_o`=1. P1, P2 and P3 never appear.
- **Reset mid-stall:** `rst_n` low for 1 cycle while FULL → outputs and state return to their reset values. With `FETCH_COMPACT_PERF_EN`, both counters read 0.
- **Perf counters:** with the macro defined, push 4'b0111 then 4'b0001 and stall 5 cycles → `perf_push_cnt_o`=4, `perf_stall_cnt_o`=5.
